// File: rtl/dma_io_peripheral.sv
// Device-side endpoint of an 8237-style DMA channel: DREQ/DACK handshake with
// a TX FIFO sourced on IOR_N strobes and an RX FIFO filled on IOW_N strobes.
module dma_io_peripheral #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              XFER_DIR,
    input  logic              DEMAND,
    input  logic              DACK,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic              EOP_N,
    input  logic [DATA_W-1:0] DB_IN,
    output logic [DATA_W-1:0] DB_OUT,
    output logic              DB_OE,
    output logic              DREQ,
    input  logic              TX_PUSH,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              TX_FULL,
    input  logic              RX_POP,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_EMPTY,
    output logic              TC,
    input  logic              TC_CLR,
    output logic              UNDERRUN,
    output logic              OVERRUN
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StReq     = 3'd1;
    localparam logic [2:0] StXfer    = 3'd2;
    localparam logic [2:0] StRelease = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              dreq_q, tc_q, tc_d, underrun_q, overrun_q;
    logic              ior_q, iow_q;
    logic [DATA_W-1:0] db_latch_q;

    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [AW:0]       tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0]       rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_empty_d, rx_full_d;
    logic ior_done, iow_done, eop;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ready, ready_d;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

    // A strobe completes on its rising edge, only while acknowledged and in the active direction.
    assign ior_done = DACK & ~ior_q & IOR_N & ~XFER_DIR;
    assign iow_done = DACK & ~iow_q & IOW_N & XFER_DIR;
    assign eop      = DACK & ~EOP_N;

    assign tx_push = TX_PUSH & ~tx_full;
    assign tx_pop  = ior_done & ~tx_empty;
    assign rx_push = iow_done & ~rx_full;
    assign rx_pop  = RX_POP & ~rx_empty;

    assign tx_wptr_d = tx_wptr_q + {{AW{1'b0}}, tx_push};
    assign tx_rptr_d = tx_rptr_q + {{AW{1'b0}}, tx_pop};
    assign rx_wptr_d = rx_wptr_q + {{AW{1'b0}}, rx_push};
    assign rx_rptr_d = rx_rptr_q + {{AW{1'b0}}, rx_pop};

    assign tx_empty_d = (tx_wptr_d == tx_rptr_d);
    assign rx_full_d  = (rx_wptr_d[AW] != rx_rptr_d[AW]) &&
                        (rx_wptr_d[AW-1:0] == rx_rptr_d[AW-1:0]);

    assign ready   = XFER_DIR ? ~rx_full   : ~tx_empty;
    assign ready_d = XFER_DIR ? ~rx_full_d : ~tx_empty_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (ENABLE && ready) state_d = StReq;
            StReq: begin
                if (DACK)         state_d = StXfer;
                else if (!ENABLE) state_d = StIdle;
            end
            StXfer: begin
                if (ior_done || iow_done)
                    state_d = (DEMAND && ENABLE && ready_d) ? StXfer : StRelease;
            end
            StRelease: if (!DACK) state_d = StIdle;
            StDone:    if (TC_CLR) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // Terminal count overrides every state.
        if (eop) state_d = StDone;
    end

    always_comb begin
        tc_d = tc_q;
        if (eop)         tc_d = 1'b1;
        else if (TC_CLR) tc_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            dreq_q     <= 1'b0;
            tc_q       <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            ior_q      <= 1'b1;
            iow_q      <= 1'b1;
            db_latch_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
        end else begin
            state_q    <= state_d;
            dreq_q     <= (state_d == StReq) || (state_d == StXfer);
            tc_q       <= tc_d;
            underrun_q <= underrun_q | (ior_done & tx_empty);
            overrun_q  <= overrun_q | (iow_done & rx_full);
            ior_q      <= IOR_N;
            iow_q      <= IOW_N;
            if (!IOW_N) db_latch_q <= DB_IN;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET_N && tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= TX_DATA;
        if (RESET_N && rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= db_latch_q;
    end

    assign DB_OUT   = tx_empty ? {DATA_W{1'b1}} : tx_mem[tx_rptr_q[AW-1:0]];
    assign DB_OE    = DACK & ~IOR_N & ~XFER_DIR;
    assign DREQ     = dreq_q;
    assign TX_FULL  = tx_full;
    assign RX_DATA  = rx_mem[rx_rptr_q[AW-1:0]];
    assign RX_EMPTY = rx_empty;
    assign TC       = tc_q;
    assign UNDERRUN = underrun_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Bench for dma_io_peripheral: directed protocol scenarios with literal expectations,
// then randomized bus traffic checked every cycle against a queue-based reference model.
module tb_dma_io_peripheral;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    localparam int PhIdle    = 0;
    localparam int PhReq     = 1;
    localparam int PhXfer    = 2;
    localparam int PhRelease = 3;
    localparam int PhDone    = 4;

    logic              clk = 1'b0;
    logic              RESET_N = 1'b0, ENABLE = 1'b0, XFER_DIR = 1'b0, DEMAND = 1'b0;
    logic              DACK = 1'b0, IOR_N = 1'b1, IOW_N = 1'b1, EOP_N = 1'b1;
    logic [DATA_W-1:0] DB_IN = '0, TX_DATA = '0;
    logic              TX_PUSH = 1'b0, RX_POP = 1'b0, TC_CLR = 1'b0;
    logic [DATA_W-1:0] DB_OUT, RX_DATA;
    logic              DB_OE, DREQ, TX_FULL, RX_EMPTY, TC, UNDERRUN, OVERRUN;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_io_peripheral #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .CLK(clk), .RESET_N(RESET_N), .ENABLE(ENABLE), .XFER_DIR(XFER_DIR),
        .DEMAND(DEMAND), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DREQ(DREQ),
        .TX_PUSH(TX_PUSH), .TX_DATA(TX_DATA), .TX_FULL(TX_FULL),
        .RX_POP(RX_POP), .RX_DATA(RX_DATA), .RX_EMPTY(RX_EMPTY),
        .TC(TC), .TC_CLR(TC_CLR), .UNDERRUN(UNDERRUN), .OVERRUN(OVERRUN)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, channel phase advanced from the protocol rules.
    logic [DATA_W-1:0] m_tx[$];
    logic [DATA_W-1:0] m_rx[$];
    logic [DATA_W-1:0] m_db = '0;
    int m_phase = PhIdle;
    bit m_on = 0, m_dreq = 0, m_tc = 0, m_und = 0, m_ovr = 0;
    bit m_ior_prev = 1, m_iow_prev = 1;

    always @(posedge clk) begin : model
        bit ior_done, iow_done, eop, tx_full_now, rx_full_now, rdy_before, rdy_after;
        int nxt;
        if (!RESET_N) begin
            m_tx.delete();
            m_rx.delete();
            m_phase = PhIdle;
            m_dreq = 0; m_tc = 0; m_und = 0; m_ovr = 0;
            m_ior_prev = 1; m_iow_prev = 1; m_db = '0;
            m_on = 1;
        end else if (m_on) begin
            ior_done    = DACK && !m_ior_prev && IOR_N && !XFER_DIR;
            iow_done    = DACK && !m_iow_prev && IOW_N && XFER_DIR;
            eop         = DACK && !EOP_N;
            tx_full_now = (m_tx.size() == DEPTH);
            rx_full_now = (m_rx.size() == DEPTH);
            rdy_before  = XFER_DIR ? !rx_full_now : (m_tx.size() != 0);

            if (ior_done) begin
                if (m_tx.size() == 0) m_und = 1;
                else void'(m_tx.pop_front());
            end
            if (TX_PUSH && !tx_full_now) m_tx.push_back(TX_DATA);
            if (RX_POP && m_rx.size() != 0) void'(m_rx.pop_front());
            if (iow_done) begin
                if (rx_full_now) m_ovr = 1;
                else m_rx.push_back(m_db);
            end
            rdy_after = XFER_DIR ? (m_rx.size() < DEPTH) : (m_tx.size() != 0);

            nxt = m_phase;
            case (m_phase)
                PhIdle:    if (ENABLE && rdy_before) nxt = PhReq;
                PhReq:     if (DACK) nxt = PhXfer; else if (!ENABLE) nxt = PhIdle;
                PhXfer:    if (ior_done || iow_done)
                               nxt = (DEMAND && ENABLE && rdy_after) ? PhXfer : PhRelease;
                PhRelease: if (!DACK) nxt = PhIdle;
                default:   if (TC_CLR) nxt = PhIdle;
            endcase
            if (eop) nxt = PhDone;
            if (eop) m_tc = 1;
            else if (TC_CLR) m_tc = 0;
            m_phase = nxt;
            m_dreq  = (nxt == PhReq) || (nxt == PhXfer);

            if (!IOW_N) m_db = DB_IN;
            m_ior_prev = IOR_N;
            m_iow_prev = IOW_N;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("dreq", DREQ, m_dreq);
            chk("tx_full", TX_FULL, m_tx.size() == DEPTH);
            chk("rx_empty", RX_EMPTY, m_rx.size() == 0);
            if (m_rx.size() != 0) chk("rx_data", RX_DATA, m_rx[0]);
            chk("db_out", DB_OUT, (m_tx.size() != 0) ? m_tx[0] : 8'hFF);
            chk("db_oe", DB_OE, DACK && !IOR_N && !XFER_DIR);
            chk("tc", TC, m_tc);
            chk("underrun", UNDERRUN, m_und);
            chk("overrun", OVERRUN, m_ovr);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_dreq(input string name);
        for (int k = 0; k < 20 && DREQ !== 1'b1; k++) cyc();
        chk(name, DREQ, 1'b1);
    endtask

    // One acknowledged byte: single strobe pulse, optional EOP on its completion.
    task automatic dma_byte(input bit dir, input bit with_eop, input logic [DATA_W-1:0] db,
                            output logic [DATA_W-1:0] seen);
        wait_dreq("dreq_wait");
        DACK = 1'b1;
        cyc();
        if (dir) begin
            DB_IN = db;
            IOW_N = 1'b0;
        end else begin
            IOR_N = 1'b0;
        end
        #1;
        seen = DB_OUT;
        cyc();
        IOR_N = 1'b1;
        IOW_N = 1'b1;
        EOP_N = with_eop ? 1'b0 : 1'b1;
        cyc();
        EOP_N = 1'b1;
        DACK  = 1'b0;
        cyc();
    endtask

    initial begin
        logic [DATA_W-1:0] seen;
        logic [DATA_W-1:0] eop_bytes [3];
        eop_bytes[0] = 8'h11; eop_bytes[1] = 8'h22; eop_bytes[2] = 8'h33;

        cyc(2);
        RESET_N = 1'b1;
        chk("rst_dreq", DREQ, 1'b0);
        chk("rst_tx_full", TX_FULL, 1'b0);
        chk("rst_rx_empty", RX_EMPTY, 1'b1);
        chk("rst_tc", TC, 1'b0);
        chk("rst_underrun", UNDERRUN, 1'b0);
        chk("rst_overrun", OVERRUN, 1'b0);

        // Single-mode device->memory byte.
        TX_PUSH = 1'b1; TX_DATA = 8'hA5;
        cyc();
        TX_PUSH = 1'b0; ENABLE = 1'b1;
        cyc();
        chk("single_dreq_up", DREQ, 1'b1);
        chk("single_db_out", DB_OUT, 8'hA5);
        DACK = 1'b1;
        cyc();
        IOR_N = 1'b0;
        #1;
        chk("single_db_oe", DB_OE, 1'b1);
        chk("single_db_strobe", DB_OUT, 8'hA5);
        cyc();
        IOR_N = 1'b1;
        cyc();
        chk("single_dreq_down", DREQ, 1'b0);
        chk("single_tx_drained", DB_OUT, 8'hFF);
        DACK = 1'b0; ENABLE = 1'b0;
        cyc();

        // Demand-mode memory->device burst until RX fills.
        XFER_DIR = 1'b1; DEMAND = 1'b1; ENABLE = 1'b1;
        cyc();
        chk("demand_dreq_up", DREQ, 1'b1);
        DACK = 1'b1;
        cyc();
        for (int i = 0; i < DEPTH; i++) begin
            DB_IN = 8'(i);
            IOW_N = 1'b0;
            cyc();
            IOW_N = 1'b1;
            cyc();
            chk($sformatf("demand_dreq_%0d", i), DREQ, i < DEPTH - 1);
        end
        DACK = 1'b0; ENABLE = 1'b0;
        cyc();
        chk("demand_rx_full_head", RX_DATA, 8'h00);

        // Overrun: one more byte into a full RX FIFO.
        DACK = 1'b1; DB_IN = 8'h55; IOW_N = 1'b0;
        cyc();
        IOW_N = 1'b1;
        cyc();
        chk("overrun_flag", OVERRUN, 1'b1);
        DACK = 1'b0;
        cyc();
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("rx_order_%0d", i), RX_DATA, i);
            RX_POP = 1'b1;
            cyc();
            RX_POP = 1'b0;
        end
        chk("rx_drained", RX_EMPTY, 1'b1);
        XFER_DIR = 1'b0; DEMAND = 1'b0;

        // Underrun: IOR strobe against an empty TX FIFO.
        DACK = 1'b1; IOR_N = 1'b0;
        cyc();
        chk("underrun_db_out", DB_OUT, 8'hFF);
        chk("underrun_db_oe", DB_OE, 1'b1);
        IOR_N = 1'b1;
        cyc();
        chk("underrun_flag", UNDERRUN, 1'b1);
        DACK = 1'b0;
        cyc();

        // EOP on the second of three bytes.
        for (int i = 0; i < 3; i++) begin
            TX_PUSH = 1'b1; TX_DATA = eop_bytes[i];
            cyc();
        end
        TX_PUSH = 1'b0; ENABLE = 1'b1;
        dma_byte(1'b0, 1'b0, 8'h00, seen);
        chk("eop_byte0", seen, 8'h11);
        dma_byte(1'b0, 1'b1, 8'h00, seen);
        chk("eop_byte1", seen, 8'h22);
        chk("eop_tc", TC, 1'b1);
        chk("eop_dreq_low", DREQ, 1'b0);
        chk("eop_remaining", DB_OUT, 8'h33);
        cyc(3);
        chk("eop_dreq_held_low", DREQ, 1'b0);
        TC_CLR = 1'b1;
        cyc();
        TC_CLR = 1'b0;
        chk("eop_tc_cleared", TC, 1'b0);
        wait_dreq("eop_dreq_back");
        dma_byte(1'b0, 1'b0, 8'h00, seen);
        chk("eop_byte2", seen, 8'h33);
        ENABLE = 1'b0;
        cyc();

        // Reset while a transfer is acknowledged and a strobe is low.
        TX_PUSH = 1'b1; TX_DATA = 8'h44;
        cyc();
        TX_PUSH = 1'b0; ENABLE = 1'b1;
        wait_dreq("rstx_dreq");
        DACK = 1'b1;
        cyc();
        IOR_N = 1'b0;
        cyc();
        RESET_N = 1'b0;
        cyc();
        RESET_N = 1'b1; IOR_N = 1'b1;
        chk("rstx_dreq_low", DREQ, 1'b0);
        chk("rstx_tx_full", TX_FULL, 1'b0);
        chk("rstx_rx_empty", RX_EMPTY, 1'b1);
        chk("rstx_tc", TC, 1'b0);
        chk("rstx_underrun", UNDERRUN, 1'b0);
        chk("rstx_overrun", OVERRUN, 1'b0);
        chk("rstx_tx_empty", DB_OUT, 8'hFF);
        cyc();
        chk("rstx_no_stray_completion", UNDERRUN, 1'b0);
        DACK = 1'b0; ENABLE = 1'b0;
        cyc();

        // Strobes without DACK leave everything alone.
        TX_PUSH = 1'b1; TX_DATA = 8'h66;
        cyc();
        TX_PUSH = 1'b0; IOR_N = 1'b0;
        #1;
        chk("stray_db_oe", DB_OE, 1'b0);
        cyc();
        IOR_N = 1'b1;
        cyc();
        chk("stray_tx_kept", DB_OUT, 8'h66);
        XFER_DIR = 1'b1; DB_IN = 8'h77; IOW_N = 1'b0;
        cyc();
        IOW_N = 1'b1;
        cyc();
        chk("stray_rx_empty", RX_EMPTY, 1'b1);
        XFER_DIR = 1'b0;
        cyc();

        // Randomized controller and local-side traffic.
        for (int n = 0; n < 5000; n++) begin
            RESET_N = ($urandom_range(0, 499) != 0);
            ENABLE  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) XFER_DIR = ~XFER_DIR;
            if ($urandom_range(0, 29) == 0) DEMAND = ~DEMAND;
            TX_PUSH = ($urandom_range(0, 2) == 0);
            TX_DATA = 8'($urandom);
            RX_POP  = ($urandom_range(0, 3) == 0);
            if (DREQ) DACK = ($urandom_range(0, 9) < 7);
            else if (DACK) DACK = ($urandom_range(0, 9) < 8);
            else DACK = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) < 4) IOR_N = ~IOR_N;
            if ($urandom_range(0, 9) < 4) IOW_N = ~IOW_N;
            TC_CLR = ($urandom_range(0, 19) == 0);
            EOP_N  = !(!TC_CLR && ($urandom_range(0, 39) == 0));
            DB_IN  = 8'($urandom);
            cyc();
        end

        RESET_N = 1'b1; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
